// File: rtl/pulse_arbiter_pkg.sv
// Shared types and constant helpers for the pulse arbiter.
// Holds the sequencer state enum and phase terminal-count helpers.
package pulse_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      PULSE,
      DONE,
      GUARD
   } state_t;

   localparam int NUM_REQ_DFLT = 4;
   localparam int IDX_W = $clog2(NUM_REQ_DFLT);

   function automatic int idx_w(int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // A phase of n cycles ends when its counter reaches n-1.
   function automatic int term(int n);
      return (n > 0) ? n - 1 : 0;
   endfunction

endpackage

// File: rtl/pulse_arbiter_if.sv
// Request/pulse bundle between requesters and the pulse arbiter.
// master = requester side, slave = arbiter side.
interface pulse_arbiter_if
   import pulse_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 5
) ();

   localparam int IW = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [CNT_W-1:0]   width_in;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      owner;
   logic               busy;
   logic               pulse;
   logic [NUM_REQ-1:0] done;

   modport master (
      output req, width_in,
      input  grant, owner, busy, pulse, done
   );

   modport slave (
      input  req, width_in,
      output grant, owner, busy, pulse, done
   );

endinterface

// File: rtl/pulse_arbiter_rr_picker.sv
// Combinational round-robin select: first set req bit at or after ptr.
// Returns one-hot winner, its index and a valid flag.
module rr_picker
   import pulse_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   localparam logic [IW:0] NN = (IW + 1)'(N);

   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   logic [IW:0]   sum;

   // Rotate so ptr sits at bit 0, find lowest set bit, rotate index back.
   always_comb begin
      rot = N'({req, req} >> ptr);
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = IW'(i);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NN) sum = sum - NN;
      idx    = sum[IW-1:0];
      valid  = |req;
      onehot = valid ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin shared delayed-pulse generator.
// Each grant runs DELAY -> PULSE -> DONE -> GUARD before the next.
module pulse_arbiter
   import pulse_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CNT_W        = 5,
   parameter int DELAY_WIDTH  = 3,
   parameter int GUARD_CYCLES = 1
) (
   input logic            clk,
   input logic            reset,
   pulse_arbiter_if.slave bus
);

   localparam int IW = idx_w(NUM_REQ);
   localparam logic [CNT_W-1:0] D_TERM = CNT_W'(term(DELAY_WIDTH));
   localparam logic [CNT_W-1:0] G_TERM = CNT_W'(term(GUARD_CYCLES));
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [IW-1:0]    LAST   = IW'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   wcnt_q, wcnt_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               pulse_q, pulse_d;

   logic [NUM_REQ-1:0] win_oh;
   logic [IW-1:0]      win_idx;
   logic               win_vld;

   rr_picker #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .onehot (win_oh),
      .idx    (win_idx),
      .valid  (win_vld)
   );

   // Next state and next registered outputs; counters end on terminal compare.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      pulse_d = 1'b0;
      done_d  = '0;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            if (win_vld) begin
               grant_d = win_oh;
               owner_d = win_idx;
               wcnt_d  = bus.width_in;
               cnt_d   = '0;
               ptr_d   = (win_idx == LAST) ? '0 : win_idx + IW'(1);
               if (DELAY_WIDTH > 0) begin
                  state_d = DELAY;
               end else if (bus.width_in == '0) begin
                  state_d = DONE;
                  done_d  = win_oh;
               end else begin
                  state_d = PULSE;
                  pulse_d = 1'b1;
               end
            end
         end
         DELAY: begin
            if (cnt_q == D_TERM) begin
               cnt_d = '0;
               if (wcnt_q == '0) begin
                  state_d = DONE;
                  done_d  = grant_q;
               end else begin
                  state_d = PULSE;
                  pulse_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         PULSE: begin
            if (cnt_q == wcnt_q - ONE) begin
               state_d = DONE;
               done_d  = grant_q;
            end else begin
               cnt_d   = cnt_q + ONE;
               pulse_d = 1'b1;
            end
         end
         DONE: begin
            grant_d = '0;
            cnt_d   = '0;
            if (GUARD_CYCLES > 0) state_d = GUARD;
            else state_d = IDLE;
         end
         GUARD: begin
            if (cnt_q == G_TERM) state_d = IDLE;
            else cnt_d = cnt_q + ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any sequence at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.owner = owner_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.pulse = pulse_q;
   assign bus.done  = done_q;

endmodule
